// File: rtl/hatch_ctrl_pkg.sv
// Shared definitions for the egg-hatching controller: state encoding,
// display stage codes and the default clock rate.
package hatch_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_INCUBATE = 3'd1,
      ST_PAUSE    = 3'd2,
      ST_HATCHED  = 3'd3,
      ST_FAILED   = 3'd4
   } state_t;

   localparam logic [3:0] STAGE_HATCHED = 4'd8;
   localparam logic [3:0] STAGE_FAILED  = 4'd9;
   localparam int         DEFAULT_CLK_HZ = 1000;

endpackage

// File: rtl/sec_prescaler.sv
// One-second prescaler: counts clock cycles and pulses sec_tick for one
// cycle each time the count wraps. Clear wins over enable.
module sec_prescaler
   import hatch_ctrl_pkg::*;
#(
   parameter int CLK_HZ = DEFAULT_CLK_HZ
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic sec_tick
);

   localparam int            CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

   logic [CW-1:0] cnt;

   // Cycle counter, held at zero while cleared, wrapping at CLK_HZ-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   assign sec_tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/hatch_ctrl.sv
// Egg-hatching controller: walks an incubation through eight stages while
// the temperature is good, pauses while it is bad, and gives up after too
// many consecutive bad seconds. Drives a stage number for the display.
module hatch_ctrl
   import hatch_ctrl_pkg::*;
#(
   parameter int CLK_HZ    = DEFAULT_CLK_HZ,
   parameter int STAGE_SEC = 3,
   parameter int FAIL_SEC  = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       st_sw,
   input  logic       temp_in,
   output logic [3:0] num,
   output logic       st,
   output logic       temp,
   output logic       hatched,
   output logic       failed
);

   localparam int             SCW        = (STAGE_SEC > 1) ? $clog2(STAGE_SEC) : 1;
   localparam int             BCW        = (FAIL_SEC > 1) ? $clog2(FAIL_SEC) : 1;
   localparam logic [SCW-1:0] STAGE_LAST = SCW'(STAGE_SEC - 1);
   localparam logic [BCW-1:0] BAD_LAST   = BCW'(FAIL_SEC - 1);

   logic           st_meta, st_s;
   logic           temp_meta, temp_s;
   logic [1:0]     warm;
   logic           armed, armed_nxt;
   state_t         state, state_nxt;
   logic [3:0]     stage, stage_nxt;
   logic [SCW-1:0] stage_cnt, stage_cnt_nxt;
   logic [BCW-1:0] bad_cnt, bad_cnt_nxt;
   logic           sec_tick;
   logic           presc_en, presc_clr;

   // Two-flop synchronizers for the asynchronous switch and sensor inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_meta   <= 1'b0;
         st_s      <= 1'b0;
         temp_meta <= 1'b0;
         temp_s    <= 1'b0;
      end else begin
         st_meta   <= st_sw;
         st_s      <= st_meta;
         temp_meta <= temp_in;
         temp_s    <= temp_meta;
      end
   end

   // Marks when the synchronizer output reflects the real switch, so the
   // reset value of st_s is never mistaken for the switch being off.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         warm <= 2'b00;
      end else begin
         warm <= {warm[0], 1'b1};
      end
   end

   assign presc_en  = (state != ST_IDLE);
   assign presc_clr = (state == ST_IDLE);

   sec_prescaler #(
      .CLK_HZ (CLK_HZ)
   ) u_prescaler (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (presc_en),
      .clr      (presc_clr),
      .sec_tick (sec_tick)
   );

   // State, stage and second counters; armed remembers a genuine switch-off.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         stage     <= '0;
         stage_cnt <= '0;
         bad_cnt   <= '0;
         armed     <= 1'b0;
      end else begin
         state     <= state_nxt;
         stage     <= stage_nxt;
         stage_cnt <= stage_cnt_nxt;
         bad_cnt   <= bad_cnt_nxt;
         armed     <= armed_nxt;
      end
   end

   // Next-state logic; switch-off overrides everything, and a tick in
   // INCUBATE counts as good even when the temperature turns bad that cycle.
   always_comb begin
      state_nxt     = state;
      stage_nxt     = stage;
      stage_cnt_nxt = stage_cnt;
      bad_cnt_nxt   = bad_cnt;
      armed_nxt     = armed;

      if (!st_s) begin
         state_nxt     = ST_IDLE;
         stage_nxt     = '0;
         stage_cnt_nxt = '0;
         bad_cnt_nxt   = '0;
         armed_nxt     = warm[1];
      end else begin
         case (state)
            ST_IDLE: begin
               if (armed) begin
                  state_nxt     = ST_INCUBATE;
                  stage_nxt     = '0;
                  stage_cnt_nxt = '0;
                  bad_cnt_nxt   = '0;
                  armed_nxt     = 1'b0;
               end
            end
            ST_INCUBATE: begin
               if (sec_tick && (stage_cnt == STAGE_LAST) &&
                   (stage == STAGE_HATCHED - 4'd1)) begin
                  stage_cnt_nxt = '0;
                  stage_nxt     = STAGE_HATCHED;
                  state_nxt     = ST_HATCHED;
               end else begin
                  if (sec_tick) begin
                     if (stage_cnt == STAGE_LAST) begin
                        stage_cnt_nxt = '0;
                        stage_nxt     = stage + 4'd1;
                     end else begin
                        stage_cnt_nxt = stage_cnt + 1'b1;
                     end
                  end
                  if (temp_s) begin
                     state_nxt = ST_PAUSE;
                  end
               end
            end
            ST_PAUSE: begin
               if (sec_tick && (bad_cnt == BAD_LAST)) begin
                  state_nxt = ST_FAILED;
               end else if (!temp_s) begin
                  state_nxt   = ST_INCUBATE;
                  bad_cnt_nxt = '0;
               end else if (sec_tick) begin
                  bad_cnt_nxt = bad_cnt + 1'b1;
               end
            end
            ST_HATCHED: begin
               state_nxt = ST_HATCHED;
            end
            ST_FAILED: begin
               state_nxt = ST_FAILED;
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Registered display and status outputs derived from the current state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num     <= '0;
         st      <= 1'b0;
         temp    <= 1'b0;
         hatched <= 1'b0;
         failed  <= 1'b0;
      end else begin
         if (state == ST_FAILED) begin
            num <= STAGE_FAILED;
         end else if (state == ST_IDLE) begin
            num <= '0;
         end else begin
            num <= stage;
         end
         st      <= (state != ST_IDLE);
         temp    <= temp_s;
         hatched <= (state == ST_HATCHED);
         failed  <= (state == ST_FAILED);
      end
   end

endmodule

// File: tb/tb_hatch_ctrl.sv
// Testbench for hatch_ctrl with a 4 Hz prescaler, 3 s stages and 5 s
// failure limit: a table of timed input steps with expected outputs, then
// a walk through all stages checking the 12-cycle stage period.
module tb_hatch_ctrl;

   logic       clk;
   logic       rst_n;
   logic       st_sw;
   logic       temp_in;
   logic [3:0] num;
   logic       st;
   logic       temp;
   logic       hatched;
   logic       failed;

   int total_checks = 0;
   int bad_checks   = 0;

   typedef struct {
      logic       rst_n;
      logic       st_sw;
      logic       temp_in;
      int         cycles;
      logic [3:0] num;
      logic       st;
      logic       temp;
      logic       hatched;
      logic       failed;
   } vec_t;

   vec_t vecs[$];

   hatch_ctrl #(
      .CLK_HZ    (4),
      .STAGE_SEC (3),
      .FAIL_SEC  (5)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .st_sw   (st_sw),
      .temp_in (temp_in),
      .num     (num),
      .st      (st),
      .temp    (temp),
      .hatched (hatched),
      .failed  (failed)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] timeout");
   end

   function automatic vec_t mk(input logic r, input logic s, input logic t,
                               input int n, input logic [3:0] en,
                               input logic es, input logic et,
                               input logic eh, input logic ef);
      vec_t v;
      v.rst_n   = r;
      v.st_sw   = s;
      v.temp_in = t;
      v.cycles  = n;
      v.num     = en;
      v.st      = es;
      v.temp    = et;
      v.hatched = eh;
      v.failed  = ef;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total_checks++;
      if (actual !== expected) begin
         bad_checks++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rst_n   = v.rst_n;
      st_sw   = v.st_sw;
      temp_in = v.temp_in;
      if (v.cycles == 0) begin
         #2;
      end else begin
         repeat (v.cycles) @(posedge clk);
         @(negedge clk);
      end
   endtask

   logic [3:0] last_num;
   int         last_cyc;
   bit         st_drop;
   bit         done;

   initial begin
      rst_n   = 1'b0;
      st_sw   = 1'b0;
      temp_in = 1'b0;

      //              rst sw tmp cyc  num st tmp hat fail
      vecs.push_back(mk(0, 0, 0,  3,  0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0,  4,  0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0,  6,  0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 37,  3, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1,  8,  3, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 0,  6,  3, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0,  4,  4, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 45,  7, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0,  3,  8, 1, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0,  4,  0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0,  6,  0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 24,  2, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 18,  2, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 1,  6,  9, 1, 1, 0, 1));
      vecs.push_back(mk(1, 0, 0,  4,  0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0,  6,  0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 62,  5, 1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0,  4,  0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0,  6,  0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 20,  1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0,  0,  0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0,  2,  0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 20,  0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0,  4,  0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0,  6,  0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0,  4,  0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0,  4,  0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1,  1,  0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 12,  1, 1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0,  4,  0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0,  4,  0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 20,  0, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 1,  6,  9, 1, 1, 0, 1));
      vecs.push_back(mk(1, 0, 0,  4,  0, 0, 0, 0, 0));

      @(negedge clk);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("v%0d.num", i),     32'(num),     32'(vecs[i].num));
         checkOutput($sformatf("v%0d.st", i),      32'(st),      32'(vecs[i].st));
         checkOutput($sformatf("v%0d.temp", i),    32'(temp),    32'(vecs[i].temp));
         checkOutput($sformatf("v%0d.hatched", i), 32'(hatched), 32'(vecs[i].hatched));
         checkOutput($sformatf("v%0d.failed", i),  32'(failed),  32'(vecs[i].failed));
      end

      $display("[TB] full incubation walk");
      st_sw    = 1'b1;
      temp_in  = 1'b0;
      last_num = 4'd0;
      last_cyc = 0;
      st_drop  = 1'b0;
      done     = 1'b0;
      for (int c = 1; c <= 200 && !done; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c > 4 && st !== 1'b1) st_drop = 1'b1;
         if (num !== last_num) begin
            if (last_num != 4'd0) checkOutput("stage_interval", 32'(c - last_cyc), 32'd12);
            checkOutput("stage_step", 32'(num), 32'(last_num + 4'd1));
            last_num = num;
            last_cyc = c;
         end
         if (hatched === 1'b1) done = 1'b1;
      end
      checkOutput("hatch_reached", 32'(done), 32'd1);
      checkOutput("hatch_num", 32'(num), 32'd8);
      checkOutput("st_held", 32'(st_drop), 32'd0);

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule

// File: doc/hatch_ctrl.md
HATCH_CTRL -- requirements
Module: hatch_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 1000: input clock frequency in Hz, used for the 1 s prescaler.
REQ-002 Parameter STAGE_SEC, default 3: good-temperature seconds per hatching stage.
REQ-003 Parameter FAIL_SEC, default 5: consecutive bad-temperature seconds before failure.
REQ-004 clk  input  1  single clock, 1 kHz display clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 st_sw  input  1  start switch (asynchronous level); 1 = run, 0 = abort/idle.
REQ-007 temp_in  input  1  temperature sensor (asynchronous); 1 = out of range, 0 = in range.
REQ-008 num  output  4  hatching stage for the dot-matrix stage (0..8 normal, 9 = failed).
REQ-009 st  output  1  display enable; 1 in every state except IDLE.
REQ-010 temp  output  1  synchronized temp_in, to the display red-overlay input.
REQ-011 hatched  output  1  level, 1 while in HATCHED.
REQ-012 failed  output  1  level, 1 while in FAILED.

Function
REQ-013 st_sw and temp_in SHALL each pass through a 2-flop synchronizer; all logic uses the synchronized values (st_s, temp_s).
REQ-014 A prescaler SHALL count 0..CLK_HZ-1 and emit a one-cycle sec_tick on wrap; it is held at 0 in IDLE and cleared on IDLE->INCUBATE.
REQ-015 States: IDLE, INCUBATE, PAUSE, HATCHED, FAILED.
REQ-016 IDLE: num=0, st=0; on st_s rising edge (st_s=1, previous 0) -> INCUBATE with stage=0, stage_cnt=0, bad_cnt=0.
REQ-017 INCUBATE: on sec_tick with temp_s=0, stage_cnt increments; when stage_cnt reaches STAGE_SEC-1 on a tick, it clears and stage increments.
REQ-018 Stage increment from 7 to 8 SHALL transition to HATCHED in the same cycle; stage never exceeds 8.
REQ-019 INCUBATE with temp_s=1 SHALL move to PAUSE on the next clock; stage_cnt holds its value.
REQ-020 PAUSE: stage and stage_cnt frozen; bad_cnt increments on each sec_tick; when bad_cnt reaches FAIL_SEC-1 on a tick -> FAILED.
REQ-021 PAUSE with temp_s=0 SHALL return to INCUBATE and clear bad_cnt; stage_cnt resumes from its held value.
REQ-022 HATCHED: num=8, hatched=1; FAILED: num=9, failed=1; both hold until st_s=0.
REQ-023 st_s=0 in any state SHALL force IDLE on the next clock, clearing stage, stage_cnt, bad_cnt; this takes priority over every other transition.
REQ-024 temp SHALL equal temp_s in every state, including IDLE.
REQ-025 All outputs SHALL be registered, with one cycle latency from state/stage update.
REQ-026 sec_tick and a temperature change in the same cycle: the state at that edge decides; a tick in INCUBATE counts as good even if temp_s rises that cycle.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear the synchronizers, prescaler, counters and state (IDLE); num=0, st=0, temp=0, hatched=0, failed=0.
REQ-028 After rst_n deasserts with st_sw already 1, no run starts until st_sw is seen 0 and then 1 again.

Structure
REQ-029 The shared package SHALL hold the state encoding, stage constants (STAGE_HATCHED=8, STAGE_FAILED=9) and default CLK_HZ.
REQ-030 One sub-module, sec_prescaler (enable/clear inputs, sec_tick output), SHALL be instantiated; the FSM stays in hatch_ctrl.

Verification
REQ-031 CLK_HZ=4, STAGE_SEC=3, temp_in=0, st_sw 0->1 -> num steps 0..8 every 12 cycles, hatched=1 after 96 cycles (+sync latency), st=1 throughout.
REQ-032 At stage 3, temp_in=1 for 2 s then 0 -> num holds 3, temp=1 during pause, run then resumes with no lost stage_cnt.
REQ-033 temp_in=1 held for FAIL_SEC=5 s at stage 2 -> num=9, failed=1; st_sw 1->0 -> IDLE, num=0, st=0.
REQ-034 st_sw dropped mid-INCUBATE at stage 5 -> IDLE within 3 cycles; re-raise restarts at num=0.
REQ-035 rst_n pulsed low mid-run with st_sw=1 -> all outputs 0 immediately; after release, stays IDLE until st_sw toggles 0->1.
REQ-036 temp_in rises in the same cycle as sec_tick in INCUBATE -> that tick counts toward stage_cnt; the next tick counts toward bad_cnt.
